// File: rtl/ahbl_splitter.sv
// ahbl_splitter: 1:N AHB-Lite address decoder with response mux and built-in ERROR default slave
module ahbl_splitter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = {32'h2000_0000, 32'h0000_0000},
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hf000_0000, 32'hf000_0000},
    parameter logic [N_PORTS-1:0]        CONN_MASK = {N_PORTS{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [W_ADDR-1:0]           src_d_pc,
    input  logic [W_DATA-1:0]           src_hartid,
    input  logic                        src_hready,
    output logic                        src_hready_resp,
    output logic                        src_hresp,
    input  logic [W_ADDR-1:0]           src_haddr,
    input  logic                        src_hwrite,
    input  logic [1:0]                  src_htrans,
    input  logic [2:0]                  src_hsize,
    input  logic [2:0]                  src_hburst,
    input  logic [3:0]                  src_hprot,
    input  logic                        src_hmastlock,
    input  logic [W_DATA-1:0]           src_hwdata,
    output logic [W_DATA-1:0]           src_hrdata,
    input  logic                        src_hexcl,
    input  logic [7:0]                  src_hmaster,
    output logic                        src_hexokay,
    output logic [N_PORTS*W_ADDR-1:0]   dst_d_pc,
    output logic [N_PORTS*W_DATA-1:0]   dst_hartid,
    output logic [N_PORTS-1:0]          dst_hready,
    input  logic [N_PORTS-1:0]          dst_hready_resp,
    input  logic [N_PORTS-1:0]          dst_hresp,
    output logic [N_PORTS*W_ADDR-1:0]   dst_haddr,
    output logic [N_PORTS-1:0]          dst_hwrite,
    output logic [N_PORTS*2-1:0]        dst_htrans,
    output logic [N_PORTS*3-1:0]        dst_hsize,
    output logic [N_PORTS*3-1:0]        dst_hburst,
    output logic [N_PORTS*4-1:0]        dst_hprot,
    output logic [N_PORTS-1:0]          dst_hmastlock,
    output logic [N_PORTS*W_DATA-1:0]   dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]   dst_hrdata,
    output logic [N_PORTS-1:0]          dst_hexcl,
    output logic [N_PORTS*8-1:0]        dst_hmaster,
    input  logic [N_PORTS-1:0]          dst_hexokay
);

    typedef enum logic [1:0] {IDLE = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [N_PORTS-1:0]   hit, sel_a, sel_dp_q, sel_dp_d;
    logic                 active, unmapped;
    logic [W_DATA-1:0]    slv_rdata;
    logic                 unused_hready;

    // Address acceptance is taken from our own HREADYOUT; the upstream copy carries no extra information.
    assign unused_hready = src_hready;

    // Decode the address against every connected region; lowest-index hit wins.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_PORTS; i++)
            hit[i] = ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]) && CONN_MASK[i];
        sel_a    = hit & (~hit + N_PORTS'(1));
        active   = src_htrans[1];
        unmapped = active && !(|sel_a);
    end

    // Only the selected slave sees a non-IDLE transfer; everything else is broadcast.
    always_comb begin
        dst_htrans = '0;
        for (int i = 0; i < N_PORTS; i++)
            dst_htrans[i*2 +: 2] = (active && sel_a[i]) ? src_htrans : 2'b00;
    end

    assign dst_d_pc      = {N_PORTS{src_d_pc}};
    assign dst_hartid    = {N_PORTS{src_hartid}};
    assign dst_hready    = {N_PORTS{src_hready_resp}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};
    assign dst_hexcl     = {N_PORTS{src_hexcl}};
    assign dst_hmaster   = {N_PORTS{src_hmaster}};

    // Data-phase owner advances only when the current data phase completes.
    always_comb sel_dp_d = src_hready_resp ? (active ? sel_a : '0) : sel_dp_q;

    // Data-phase select register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sel_dp_q <= '0;
        else        sel_dp_q <= sel_dp_d;

    // Error FSM state register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    // Error FSM next state: a two-cycle ERROR per accepted unmapped transfer, chaining without a gap.
    always_comb state_d = (state_q == ERR1) ? ERR2 : (src_hready_resp && unmapped) ? ERR1 : IDLE;

    // Read data from the data-phase owner (zero when no slave owns the data phase).
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < N_PORTS; i++)
            slv_rdata = slv_rdata | (dst_hrdata[i*W_DATA +: W_DATA] & {W_DATA{sel_dp_q[i]}});
    end

    // Response to the master: error FSM overrides, otherwise the owning slave, otherwise an idle OKAY.
    always_comb begin
        src_hready_resp = (state_q == ERR1) ? 1'b0 :
                          (state_q == ERR2) ? 1'b1 :
                          (|sel_dp_q)       ? |(sel_dp_q & dst_hready_resp) : 1'b1;
        src_hresp       = (state_q != IDLE) ? 1'b1 : |(sel_dp_q & dst_hresp);
        src_hrdata      = (state_q != IDLE) ? '0 : slv_rdata;
        src_hexokay     = (state_q != IDLE) ? 1'b0 : |(sel_dp_q & dst_hexokay);
    end

endmodule
